// File: rtl/rot_pkg.sv
// Shared types and constants for the rotator issue queue slice.
package rot_pkg;

  localparam int ROT_DATA_W = 8;
  localparam int ROT_AMT_W  = 3;

  typedef struct packed {
    logic [ROT_DATA_W-1:0] data;
    logic [ROT_AMT_W-1:0]  amt;
  } rot_req_t;

  typedef enum logic {
    R_EMPTY = 1'b0,
    R_FULL  = 1'b1
  } res_state_t;

endpackage

// File: rtl/rot_issue_queue_if.sv
// Request, rotator and result signals of the rotator issue queue.
// master = surrounding logic (producer, rotator, consumer); slave = the queue.
interface rot_issue_queue_if;
  import rot_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [ROT_DATA_W-1:0] in_data;
  logic [ROT_AMT_W-1:0]  in_amt;
  logic [ROT_DATA_W-1:0] rot_data;
  logic [ROT_AMT_W-1:0]  rot_sel;
  logic [ROT_DATA_W-1:0] rot_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [ROT_DATA_W-1:0] out_data;
  logic                  err;

  modport master (
    output in_valid, in_data, in_amt, rot_result, out_ready,
    input  in_ready, rot_data, rot_sel, out_valid, out_data, err
  );

  modport slave (
    input  in_valid, in_data, in_amt, rot_result, out_ready,
    output in_ready, rot_data, rot_sel, out_valid, out_data, err
  );

endinterface

// File: rtl/rot_req_fifo.sv
// Request FIFO: storage plus extended pointers; full/empty from pointer compare.
// Storage is not reset; the head reads as zero when empty.
module rot_req_fifo
  import rot_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  rot_req_t wr_req,
  input  logic     pop,
  output rot_req_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  rot_req_t    mem [DEPTH];

  // Pointer update; the extra MSB distinguishes full from empty on wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_INC;
      if (pop)  rd_ptr <= rd_ptr + PTR_INC;
    end
  end

  // Storage write; push is only ever issued when not full.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_req;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rot_issue_queue.sv
// Issue queue around an external combinational 8-bit right rotator:
// request FIFO -> rot_data/rot_sel -> rotator -> rot_result -> result register.
// Optional macro ROT_SELF_CHECK_EN adds a behavioural rotate model that sets
// a sticky err on any rot_result mismatch; without it err is tied low.
module rot_issue_queue
  import rot_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input logic              clk,
  input logic              rst,
  rot_issue_queue_if.slave bus
);

  rot_req_t    wr_req;
  rot_req_t    head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  res_state_t  state_q;
  res_state_t  state_d;
  logic [DATA_W-1:0] res_data_p1;

  assign wr_req = '{data: bus.in_data, amt: bus.in_amt};

  // in_ready comes from FIFO occupancy alone, never from out_ready.
  assign bus.in_ready = ~full;
  assign push         = bus.in_valid & ~full;
  assign pop          = ~empty & ((state_q == R_EMPTY) | bus.out_ready);

  rot_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wr_req (wr_req),
    .pop    (pop),
    .head   (head),
    .full   (full),
    .empty  (empty)
  );

  assign bus.rot_data = head.data;
  assign bus.rot_sel  = head.amt;

  // Result FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= R_EMPTY;
    else     state_q <= state_d;
  end

  // Result FSM next state: fill on pop, drain when consumed with nothing behind.
  always_comb begin
    state_d = state_q;
    case (state_q)
      R_EMPTY: if (pop) state_d = R_FULL;
      R_FULL:  if (bus.out_ready && !pop) state_d = R_EMPTY;
      default: state_d = R_EMPTY;
    endcase
  end

  // ---- stage p1: rotator output captured into the result register ----
  // Result data capture; held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      res_data_p1 <= '0;
    else if (pop) res_data_p1 <= bus.rot_result;
  end

  assign bus.out_valid = (state_q == R_FULL);
  assign bus.out_data  = res_data_p1;

`ifdef ROT_SELF_CHECK_EN
  logic err_q;

  function automatic logic [ROT_DATA_W-1:0] ror_model(input rot_req_t r);
    return ROT_DATA_W'({r.data, r.data} >> r.amt);
  endfunction

  // Sticky mismatch flag comparing the rotator against the model on each pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          err_q <= 1'b0;
    else if (pop && (ror_model(head) != bus.rot_result)) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
